// File: rtl/rr_packet_arbiter_if.sv
// rr_packet_arbiter_if: request/grant bundle between N packet sources and the merged output.
interface rr_packet_arbiter_if #(parameter int N = 4);
    localparam int SELW = $clog2(N);
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic [N-1:0] in_ready;
    logic [N-1:0] gnt;
    logic [SELW-1:0] sel;
    logic out_valid;
    logic out_last;
    logic out_ready;
    logic busy;
    modport master (output req, last, out_ready, input in_ready, gnt, sel, out_valid, out_last, busy);
    modport slave (input req, last, out_ready, output in_ready, gnt, sel, out_valid, out_last, busy);
endinterface

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: round-robin arbiter holding each grant for a whole packet; drives the N:1 mux select.
module rr_packet_arbiter #(
    parameter int N = 4,
    localparam int SELW = $clog2(N)
) (
    input logic clk,
    input logic rst,
    rr_packet_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n;
    logic [N-1:0] gnt, gnt_n;
    logic [SELW-1:0] sel, sel_n, ptr, ptr_n, nxt, start, win;
    logic found, rel;

    // Returns {found, index} of the first requester at or after s, wrapping mod N.
    function automatic logic [SELW:0] pick(input logic [SELW-1:0] s, input logic [N-1:0] r);
        logic [SELW:0] res;
        int j;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(s) + k;
            if (j >= N) j -= N;
            if (r[j]) res = {1'b1, SELW'(j)};
        end
        return res;
    endfunction

    assign nxt = (sel == SELW'(N - 1)) ? '0 : sel + 1'b1;
    assign start = (state == BUSY) ? nxt : ptr;
    assign {found, win} = pick(start, bus.req);
    assign bus.busy = state == BUSY;
    assign bus.out_valid = bus.busy && bus.req[sel];
    assign bus.out_last = bus.out_valid && bus.last[sel];
    assign bus.in_ready = gnt & {N{bus.out_ready}};
    assign bus.gnt = gnt;
    assign bus.sel = sel;
    assign rel = bus.out_last && bus.out_ready;

    always_comb begin
        state_n = state;
        gnt_n = gnt;
        sel_n = sel;
        ptr_n = ptr;
        if (state == IDLE) begin
            if (found) begin
                state_n = BUSY;
                gnt_n = N'(1) << win;
                sel_n = win;
            end
        end else if (rel) begin
            ptr_n = nxt;
            state_n = found ? BUSY : IDLE;
            gnt_n = found ? N'(1) << win : '0;
            sel_n = found ? win : sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= '0;
            sel <= '0;
            ptr <= '0;
        end else begin
            state <= state_n;
            gnt <= gnt_n;
            sel <= sel_n;
            ptr <= ptr_n;
        end
    end
endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the parametric N:1 mux and drives its select line.
- Grants one of N requesters and holds the grant for a whole packet, until the beat flagged `last` is accepted downstream.
- Provides per-input ready and merged valid/last, so the arbiter plus mux form an N:1 valid/ready packet merger.

Parameters:
- N, 4, number of requesters; legal range N >= 2; non-power-of-two allowed.
- SELW, $clog2(N), width of sel; derived, must not be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- req  input  N  per-input valid; requester i holds req[i] for every beat of its packet.
- last  input  N  per-input end-of-packet flag; qualified by req[i].
- in_ready  output  N  per-input ready; equals gnt AND out_ready.
- gnt  output  N  one-hot grant, registered; all-zero when idle.
- sel  output  SELW  index of granted input, registered; drives mux sel.
- out_valid  output  1  merged valid = busy AND req[sel].
- out_last  output  1  merged last = out_valid AND last[sel].
- out_ready  input  1  downstream ready.
- busy  output  1  high while a grant is held.

Behaviour:
- State: two-state FSM, IDLE and BUSY. Registers: gnt, sel, ptr (round-robin start index, 0..N-1).
- Reset (rst=1 at edge): state IDLE, gnt=0, sel=0, ptr=0, busy=0. Combinationally this gives out_valid=0, out_last=0, in_ready=0.
- Reset mid-packet: the grant drops at that edge. The partial packet is abandoned; there is no recovery.
- Winner search: first i with req[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- IDLE:
  - If any req is high at edge t, load gnt=onehot(winner), sel=winner, busy=1, state BUSY.
  - Grant is visible from cycle t+1: one-cycle arbitration latency from idle.
  - If no req, stay IDLE.
- BUSY:
  - Grant is frozen; req changes on other inputs are ignored.
  - Beat transfer = out_valid AND out_ready.
  - Transfer with out_last=1 is the release event. On release, ptr <= (sel+1) mod N, wrapping N-1 -> 0.
  - In the same edge, re-arbitrate using start index (sel+1) mod N against the current req. The releasing input is therefore lowest priority.
    - If a winner exists: load new gnt/sel, stay BUSY, with no bubble between packets.
    - If no winner: gnt=0, busy=0, state IDLE. sel keeps its last value.
  - Transfer without last: hold grant, no state change.
  - Granted req deasserted mid-packet: grant held, out_valid=0 until req returns. No timeout.
- ptr changes only on release; never in IDLE.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt[sel]=1 whenever busy.
  - in_ready is non-zero only on the granted bit.
- Starvation bound: a continuously requesting input is granted after at most N-1 other packets.
- Outputs in_ready, out_valid and out_last are combinational from registered state, req, last and out_ready. There is no combinational path from req to gnt/sel.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req=4'b1111 → gnt=0, sel=0, busy=0, out_valid=0 throughout; first grant to input 0 one cycle after rst falls.
- Round-robin rotation: N=4, req=4'b1111, single-beat packets (last=4'b1111), out_ready=1 → sel sequence 0,1,2,3,0 on consecutive cycles with no bubbles; gnt one-hot each cycle.
- Packet hold: input 1 sends 3 beats (last on 3rd) while req=4'b1011; out_ready toggles 1,0,1,1 → sel=1 held until the 3rd accepted beat; next grant to input 3; in_ready[1] follows out_ready.
- Wrap and skip: N=3 (non-power-of-two), grant on input 2, req=3'b101 at release → next sel=0 and ptr wraps to 0; ptr never reaches 3.
- Valid gap and reset mid-packet: granted input 0 drops req for 2 cycles mid-packet → out_valid=0, grant held; then rst=1 for one edge mid-packet → gnt=0, busy=0 next cycle, and re-arbitration starts from ptr=0.
